// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// bit-counter sizing.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width max(1, clog2(n)); a one-bit counter still works for n = 1.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_serial_adder_fa.sv
// One-bit combinational full adder, the only arithmetic in the serial datapath.
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (b & ci) | (a & ci);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: {co,s} = a + b + ci computed LSB first, one bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] res_shift;

  full_add_cell u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum bits enter from the MSB side so that after WIDTH shifts bit 0 is the LSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift = fa_s;
    end else begin : g_res_wn
      assign res_shift = {fa_s, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = res_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d     = res_shift;
          co_d    = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign co        = co_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed + randomized bench for bit_serial_adder (WIDTH=8 and WIDTH=1 instances)
// against the arithmetic reference {co,s} = a + b + ci.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid8 = 1'b0, out_ready8 = 1'b0, ci8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, co8;
  logic [7:0] s8;

  logic       in_valid1 = 1'b0, out_ready1 = 1'b0, ci1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       in_ready1, out_valid1, co1;
  logic [0:0] s1;

  int checks = 0;
  int errors = 0;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .ci(ci8), .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .co(co8)
  );

  bit_serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .ci(ci1), .out_valid(out_valid1), .out_ready(out_ready1),
    .s(s1), .co(co1)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid8 after an accept edge; returns edges counted.
  task automatic wait_done8(output int lat);
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One WIDTH=8 transaction; optional result stall and operand scrambling during RUN.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input int stall, input bit scramble, input string tag);
    logic [8:0] exp;
    int lat;
    exp = 9'(a) + 9'(b) + 9'(ci);
    @(negedge clk);
    chk({tag, "_in_ready"}, 65'(in_ready8), 65'(1));
    a8 = a; b8 = b; ci8 = ci; in_valid8 = 1'b1;
    out_ready8 = (stall == 0);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    if (scramble) begin a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1; end
    else begin a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); end
    chk({tag, "_busy"}, 65'(in_ready8), 65'(0));
    wait_done8(lat);
    chk({tag, "_latency"}, 65'(lat), 65'(8));
    chk({tag, "_sum"}, 65'({co8, s8}), 65'(exp));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stall"}, 65'({out_valid8, co8, s8}), 65'({1'b1, exp}));
    end
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_idle"}, 65'({in_ready8, out_valid8}), 65'(2'b10));
    chk({tag, "_hold"}, 65'({co8, s8}), 65'(exp));
    $display("op8 %s a=%02h b=%02h ci=%0d -> co=%0d s=%02h lat=%0d stall=%0d",
             tag, a, b, ci, co8, s8, lat, stall);
  endtask

  task automatic op1(input logic a, input logic b, input logic ci);
    logic [1:0] exp;
    exp = 2'(a) + 2'(b) + 2'(ci);
    @(negedge clk);
    a1 = a; b1 = b; ci1 = ci; in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("w1_run", 65'({in_ready1, out_valid1}), 65'(2'b00));
    @(posedge clk); #1;
    chk("w1_done", 65'({out_valid1, co1, s1}), 65'({1'b1, exp}));
    @(posedge clk); #1;
    chk("w1_idle", 65'(in_ready1), 65'(1));
    $display("op1 a=%0d b=%0d ci=%0d -> co=%0d s=%0d", a, b, ci, co1, s1);
  endtask

  initial begin
    int lat;
    // Reset state
    #2;
    chk("rst_out8", 65'({in_ready8, out_valid8, co8, s8}), 65'({1'b1, 1'b0, 1'b0, 8'h00}));
    chk("rst_out1", 65'({in_ready1, out_valid1, co1, s1}), 65'(4'b1000));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases
    op8(8'h5A, 8'h3C, 1'b0, 0, 1'b0, "basic");
    op8(8'hFF, 8'h01, 1'b1, 0, 1'b0, "carry1");
    op8(8'hFF, 8'h00, 1'b1, 0, 1'b0, "ripple");

    // Result stall with the next operand set held on the input
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'h21; b8 = 8'h43; ci8 = 1'b1;
    wait_done8(lat);
    chk("stall_latency", 65'(lat), 65'(8));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", 65'({out_valid8, in_ready8, co8, s8}), 65'({1'b1, 1'b0, 1'b0, 8'h46}));
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", 65'({out_valid8, in_ready8}), 65'(2'b01));
    @(posedge clk); #1;
    chk("stall_next_accept", 65'(in_ready8), 65'(0));
    in_valid8 = 1'b0;
    wait_done8(lat);
    chk("stall_next_sum", 65'({co8, s8}), 65'(9'h21 + 9'h43 + 9'h1));
    $display("stall a=12 b=34 held 5 cycles, next 21+43+1 -> co=%0d s=%02h", co8, s8);
    @(negedge clk);

    // Operands changed after accept must not affect the result
    op8(8'h0F, 8'h01, 1'b0, 0, 1'b1, "scramble");

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; ci8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst", 65'({in_ready8, out_valid8, co8, s8}), 65'({1'b1, 1'b0, 1'b0, 8'h00}));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_result", 65'(out_valid8), 65'(0));
    $display("reset mid-RUN: in_ready=%0d out_valid=%0d s=%02h", in_ready8, out_valid8, s8);
    op8(8'h80, 8'h80, 1'b0, 0, 1'b0, "post_rst");

    // Randomized transactions with random result stalls
    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0, "rand");
    end

    // WIDTH=1: exhaustive
    op1(1'b1, 1'b1, 1'b1);
    for (int v = 0; v < 8; v++) begin
      op1(v[2], v[1], v[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
